// File: rtl/hls2x8_mac_pipe.sv
// Pipelined signed multiply-accumulate with clock-enable stall, valid sideband,
// running accumulator and fixed-point narrowing. Output saturation when HLS2X8_MAC_SAT_EN is defined.
module hls2x8_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  typedef struct packed {
    logic vld;
    logic en;
    logic clr;
  } side_t;

  side_t                 in_side;
  side_t                 fin_side;
  logic signed [PW-1:0]  fin_p;

  assign in_side = {in_valid, acc_en, acc_clr};

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign fin_p    = $signed(din0) * $signed(din1);
      assign fin_side = in_side;
    end else begin : g_piped
      side_t                  op_side_d, op_side_q;
      logic [din0_WIDTH-1:0]  op_a_d, op_a_q;
      logic [din1_WIDTH-1:0]  op_b_d, op_b_q;
      logic signed [PW-1:0]   prod;

      always_comb begin
        op_side_d = ce ? in_side : op_side_q;
        op_a_d    = ce ? din0    : op_a_q;
        op_b_d    = ce ? din1    : op_b_q;
      end

      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) op_side_q <= '0;
        else        op_side_q <= op_side_d;
      end

      // NOTE: operand and product registers carry no reset; the valid bit
      // travelling beside them is what makes their contents meaningful.
      always_ff @(posedge ap_clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
      end

      assign prod = $signed(op_a_q) * $signed(op_b_q);

      if (NUM_STAGE == 2) begin : g_no_mid
        assign fin_p    = prod;
        assign fin_side = op_side_q;
      end else begin : g_mid
        localparam int M = NUM_STAGE - 2;
        side_t                mid_side_d [M];
        side_t                mid_side_q [M];
        side_t                src_side   [M];
        logic signed [PW-1:0] mid_p_d    [M];
        logic signed [PW-1:0] mid_p_q    [M];
        logic signed [PW-1:0] src_p      [M];

        always_comb begin
          src_p[0]    = prod;
          src_side[0] = op_side_q;
          for (int i = 1; i < M; i++) begin
            src_p[i]    = mid_p_q[i-1];
            src_side[i] = mid_side_q[i-1];
          end
          for (int i = 0; i < M; i++) begin
            mid_p_d[i]    = ce ? src_p[i]    : mid_p_q[i];
            mid_side_d[i] = ce ? src_side[i] : mid_side_q[i];
          end
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
          if (ap_rst) begin
            for (int i = 0; i < M; i++) mid_side_q[i] <= '0;
          end else begin
            for (int i = 0; i < M; i++) mid_side_q[i] <= mid_side_d[i];
          end
        end

        always_ff @(posedge ap_clk) begin
          for (int i = 0; i < M; i++) mid_p_q[i] <= mid_p_d[i];
        end

        assign fin_p    = mid_p_q[M-1];
        assign fin_side = mid_side_q[M-1];
      end
    end
  endgenerate

  // Final stage: accumulate, shift, narrow.
  logic [ACC_WIDTH-1:0]        acc_d, acc_q;
  logic                        out_valid_d, out_valid_q;
  logic [dout_WIDTH-1:0]       dout_d, dout_q;
  logic                        ovf_d, ovf_q;
  logic signed [ACC_WIDTH-1:0] p_ext, acc_base, r_val, s_val;
  logic [dout_WIDTH-1:0]       s_wrap;
  logic                        s_ovf;
  logic [dout_WIDTH-1:0]       s_narrow;

`ifdef HLS2X8_MAC_SAT_EN
  localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
`endif

  always_comb begin
    p_ext    = ACC_WIDTH'(fin_p);
    acc_base = (fin_side.en && !fin_side.clr) ? acc_q : '0;
    r_val    = p_ext + acc_base;
    s_val    = r_val >>> FRAC_SHIFT;
    s_wrap   = s_val[dout_WIDTH-1:0];
    // Out of range exactly when sign-extending the narrowed value fails to restore S.
    s_ovf    = (s_val != ACC_WIDTH'($signed(s_wrap)));
`ifdef HLS2X8_MAC_SAT_EN
    s_narrow = s_ovf ? (s_val[ACC_WIDTH-1] ? DOUT_MIN : DOUT_MAX) : s_wrap;
`else
    s_narrow = s_wrap;
`endif
  end

  // NOTE: every _d takes its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (ce) begin
      out_valid_d = fin_side.vld;
      if (fin_side.vld) begin
        dout_d = s_narrow;
        ovf_d  = s_ovf;
        if (fin_side.en) acc_d = r_val;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_hls2x8_mac_pipe.sv
// Scoreboard bench for hls2x8_mac_pipe: a 3-stage unshifted instance and a
// 1-stage FRAC_SHIFT=8 instance share one stimulus stream and an arithmetic reference model.
module tb_hls2x8_mac_pipe;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          at;
  } exp_t;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b0;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic               acc_en = 1'b0;
  logic               acc_clr = 1'b0;
  logic signed [15:0] din0 = '0;
  logic signed [15:0] din1 = '0;
  logic               ov0, ov1, ovf0, ovf1;
  logic [15:0]        dout0, dout1;

  int     n_vec = 0;
  int     n_err = 0;
  int     edge_cnt = 0;
  bit     new_edge = 1'b0;
  longint acc0 = 0;
  longint acc1 = 0;
  exp_t   q0[$];
  exp_t   q1[$];

  always #5 ap_clk = ~ap_clk;

  hls2x8_mac_pipe #(.ID(1), .NUM_STAGE(3), .FRAC_SHIFT(0)) u_dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
    .acc_en(acc_en), .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .out_valid(ov0), .dout(dout0), .ovf(ovf0));

  hls2x8_mac_pipe #(.ID(2), .NUM_STAGE(1), .FRAC_SHIFT(8)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
    .acc_en(acc_en), .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .out_valid(ov1), .dout(dout1), .ovf(ovf1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact product plus accumulator, wrapped to 40 bits, shifted, range-checked.
  task automatic model(input int sh, inout longint acc, input int lat, output exp_t e);
    longint r, s;
    r = longint'(din0) * longint'(din1);
    if (acc_en && !acc_clr) r = r + acc;
    r = (r <<< 24) >>> 24;
    if (acc_en) acc = r;
    s = r >>> sh;
    e.o = (s > 32767) || (s < -32768);
    e.d = 16'(s);
`ifdef HLS2X8_MAC_SAT_EN
    if (e.o) e.d = (s < 0) ? 16'h8000 : 16'h7fff;
`endif
    e.at = edge_cnt + lat - 1;
  endtask

  always @(posedge ap_clk) begin
    exp_t e;
    new_edge = !ap_rst && ce;
    if (new_edge) begin
      edge_cnt++;
      if (in_valid) begin
        model(0, acc0, 3, e);
        q0.push_back(e);
        model(8, acc1, 1, e);
        q1.push_back(e);
      end
    end
  end

  always @(negedge ap_clk) begin
    exp_t e;
    if (new_edge) begin
      new_edge = 1'b0;
      if (ov0) begin
        if (q0.size() == 0) check("dut0 unexpected out_valid", 64'd1, 64'd0);
        else begin
          e = q0.pop_front();
          check("dut0 dout", 64'(dout0), 64'(e.d));
          check("dut0 ovf", 64'(ovf0), 64'(e.o));
          check("dut0 latency edge", 64'(edge_cnt), 64'(e.at));
        end
      end
      if (ov1) begin
        if (q1.size() == 0) check("dut1 unexpected out_valid", 64'd1, 64'd0);
        else begin
          e = q1.pop_front();
          check("dut1 dout", 64'(dout1), 64'(e.d));
          check("dut1 ovf", 64'(ovf1), 64'(e.o));
          check("dut1 latency edge", 64'(edge_cnt), 64'(e.at));
        end
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic signed [15:0] a, input logic signed [15:0] b,
                       input bit en, input bit clr);
    din0 = a; din1 = b; acc_en = en; acc_clr = clr; in_valid = 1'b1; ce = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; ce = 1'b1;
    repeat (n) step();
  endtask

  task automatic check_reset_outputs();
    check("rst dut0 out_valid", 64'(ov0), 64'd0);
    check("rst dut0 dout", 64'(dout0), 64'd0);
    check("rst dut0 ovf", 64'(ovf0), 64'd0);
    check("rst dut1 out_valid", 64'(ov1), 64'd0);
    check("rst dut1 dout", 64'(dout1), 64'd0);
    check("rst dut1 ovf", 64'(ovf1), 64'd0);
  endtask

  initial begin
    #1 ap_rst = 1'b1;
    #2 check_reset_outputs();
    repeat (2) @(posedge ap_clk);
    #3 ap_rst = 1'b0;

    // Basic latency, then narrowing.
    drive(16'sd3, -16'sd4, 1'b0, 1'b0);
    idle(4);
    drive(16'sd300, 16'sd300, 1'b0, 1'b0);
    idle(3);

    // Back-to-back accumulation, overflow on the fourth, then clear.
    drive(16'sd100, 16'sd100, 1'b1, 1'b1);
    repeat (3) drive(16'sd100, 16'sd100, 1'b1, 1'b0);
    drive(16'sd100, 16'sd100, 1'b1, 1'b1);
    idle(4);

    // Six-sample stream with a five-cycle stall in the middle.
    for (int i = 0; i < 6; i++) begin
      logic signed [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      if (i == 3) begin
        din0 = a; din1 = b; acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
        ce = 1'b0;
        repeat (5) step();
      end
      drive(a, b, 1'b1, i == 0);
    end
    idle(4);

    // Asynchronous reset with two accumulating samples in flight.
    drive(16'sd7, 16'sd9, 1'b1, 1'b1);
    drive(16'sd5, 16'sd5, 1'b1, 1'b0);
    #1 ap_rst = 1'b1;
    #1 check_reset_outputs();
    q0.delete(); q1.delete(); acc0 = 0; acc1 = 0;
    #2 ap_rst = 1'b0;
    drive(16'sd2, 16'sd3, 1'b1, 1'b0);
    idle(4);

    // Fixed-point shift and extreme operands.
    drive(-16'sd256, 16'sd3, 1'b0, 1'b0);
    drive(-16'sd32768, -16'sd32768, 1'b0, 1'b0);
    drive(16'sd32767, -16'sd32768, 1'b1, 1'b1);
    idle(4);

    // Randomized traffic with random stalls and accumulator control.
    for (int i = 0; i < 400; i++) begin
      ce       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      acc_en   = $urandom_range(0, 1) == 1;
      acc_clr  = ($urandom_range(0, 4) == 0);
      din0 = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff)
                                         : 16'($urandom);
      din1 = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff)
                                         : 16'($urandom);
      step();
    end

    in_valid = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
    step();
    check("drain dut0 pending", 64'(q0.size()), 64'd0);
    check("drain dut1 pending", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
